// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX/MEM/WB hazard tracking, ALU operand forward selects, load-use stall and stall counter
module hazard_forward_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rs1,
    input  logic [REG_W-1:0] issue_rs2,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_regwrite,
    input  logic             issue_memread,
    input  logic             flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // EX keeps its source indices for forwarding; MEM/WB only need what a
    // consumer compares against (rd and whether it is actually written).
    logic             ex_valid;
    logic [REG_W-1:0] ex_rs1;
    logic [REG_W-1:0] ex_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;

    logic             mem_valid;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;

    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             wb_regwrite;

    logic mem_fwd_ok;
    logic wb_fwd_ok;
    logic ex_load_hit;

    always_comb begin
        // A stage can only source a forward if it really writes a non-x0 rd.
        mem_fwd_ok = ex_valid && mem_valid && mem_regwrite && (mem_rd != '0);
        wb_fwd_ok  = ex_valid && wb_valid  && wb_regwrite  && (wb_rd  != '0);

        // MEM is checked first: it holds the younger value of the same rd.
        forward_a = SEL_REG;
        if (mem_fwd_ok && (mem_rd == ex_rs1)) begin
            forward_a = SEL_MEM;
        end else if (wb_fwd_ok && (wb_rd == ex_rs1)) begin
            forward_a = SEL_WB;
        end

        forward_b = SEL_REG;
        if (mem_fwd_ok && (mem_rd == ex_rs2)) begin
            forward_b = SEL_MEM;
        end else if (wb_fwd_ok && (wb_rd == ex_rs2)) begin
            forward_b = SEL_WB;
        end

        // Both sources are compared even for formats without rs2; an extra
        // stall is harmless, a missed one is not. Flush kills the consumer,
        // so there is nothing to wait for.
        ex_load_hit = ex_valid && ex_memread && ex_regwrite && (ex_rd != '0)
                      && ((ex_rd == issue_rs1) || (ex_rd == issue_rs2));
        stall = issue_valid && !flush && ex_load_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            stall_count  <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;

            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;

            if (flush || stall || !issue_valid) begin
                ex_valid    <= 1'b0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end else begin
                ex_valid    <= 1'b1;
                ex_rs1      <= issue_rs1;
                ex_rs2      <= issue_rs2;
                ex_rd       <= issue_rd;
                ex_regwrite <= issue_regwrite;
                ex_memread  <= issue_memread;
            end

            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - scoreboard bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             issue_valid;
    logic [REG_W-1:0] issue_rs1;
    logic [REG_W-1:0] issue_rs2;
    logic [REG_W-1:0] issue_rd;
    logic             issue_regwrite;
    logic             issue_memread;
    logic             flush;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    hazard_forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_regwrite(issue_regwrite),
        .issue_memread (issue_memread),
        .flush         (flush),
        .forward_a     (forward_a),
        .forward_b     (forward_b),
        .stall         (stall),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt;

    task automatic chk(input string nm, input string field, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h", nm, field, act, exp);
        end
    endtask

    // Outputs are valid every cycle; the monitor pairs each one with the
    // expectation pushed when that cycle's inputs were applied.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "forward_a",   {2'b00, forward_a}, {2'b00, e.fa});
            chk(e.name, "forward_b",   {2'b00, forward_b}, {2'b00, e.fb});
            chk(e.name, "stall",       {3'b000, stall},    {3'b000, e.st});
            chk(e.name, "stall_count", stall_count,        e.cnt);
        end
    end

    task automatic cyc(input string nm, input logic r, input logic iv,
                       input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                       input logic [REG_W-1:0] rd, input logic rw, input logic mr,
                       input logic fl, input logic [1:0] efa, input logic [1:0] efb,
                       input logic est, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2;
        issue_rd = rd; issue_regwrite = rw; issue_memread = mr; flush = fl;
        e.name = nm; e.fa = efa; e.fb = efb; e.st = est; e.cnt = ecnt[CNT_W-1:0];
        sb.push_back(e);
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++) cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, exp_cnt);
    endtask

    initial begin
        rst = 1; issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_regwrite = 0; issue_memread = 0; flush = 0;
        exp_cnt = 0;

        // reset held with a live issue: nothing may enter EX
        cyc("rst0", 1, 1, 5, 5, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("rst1", 1, 1, 5, 5, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        idle("post_rst", 3);

        // MEM -> EX forwarding on both operands
        cyc("fw_p",  0, 1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("fw_c",  0, 1, 3, 3, 4, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("fw_ex", 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0);
        idle("fw_idle", 3);

        // x0 producer never forwards
        cyc("x0_p",  0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("x0_c",  0, 1, 0, 0, 9, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("x0_ex", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle("x0_idle", 3);

        // MEM wins over WB for the same rd
        cyc("pr_p1", 0, 1, 1, 2, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("pr_p2", 0, 1, 1, 2, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("pr_c",  0, 1, 7, 8, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("pr_ex", 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        idle("pr_idle", 3);

        // non-writing middle instruction: WB supplies the value
        cyc("wb_p1", 0, 1, 1, 2, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("wb_p2", 0, 1, 1, 2, 7, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("wb_c",  0, 1, 7, 8, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc("wb_ex", 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        idle("wb_idle", 3);

        // load-use: one stall, bubble, then WB forward
        cyc("lu_ld",    0, 1, 1, 0, 6, 1, 1, 0, 2'b00, 2'b00, 0, 0);
        cyc("lu_stall", 0, 1, 1, 6, 11, 1, 0, 0, 2'b00, 2'b00, 1, 0);
        exp_cnt = 1;
        cyc("lu_reiss", 0, 1, 1, 6, 11, 1, 0, 0, 2'b00, 2'b00, 0, exp_cnt);
        cyc("lu_ex",    0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, exp_cnt);
        idle("lu_idle", 3);

        // flush in the stall cycle: no stall, no count, consumer killed
        cyc("fl_ld",   0, 1, 1, 0, 6, 1, 1, 0, 2'b00, 2'b00, 0, exp_cnt);
        cyc("fl_kill", 0, 1, 1, 6, 11, 1, 0, 1, 2'b00, 2'b00, 0, exp_cnt);
        cyc("fl_bub",  0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, exp_cnt);
        idle("fl_idle", 3);

        // flush leaves MEM/WB alone; older rd=6 still forwards from MEM
        cyc("fm_p",    0, 1, 1, 2, 6, 1, 0, 0, 2'b00, 2'b00, 0, exp_cnt);
        cyc("fm_c",    0, 1, 6, 6, 14, 1, 0, 0, 2'b00, 2'b00, 0, exp_cnt);
        cyc("fm_fl",   0, 1, 6, 6, 15, 1, 0, 1, 2'b10, 2'b10, 0, exp_cnt);
        cyc("fm_bub",  0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, exp_cnt);
        idle("fm_idle", 3);

        // 20 load-use stalls against a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            cyc("sat_ld", 0, 1, 1, 0, 6, 1, 1, 0, 2'b00, (i > 0) ? 2'b01 : 2'b00, 0, exp_cnt);
            cyc("sat_st", 0, 1, 1, 6, 11, 1, 0, 0, 2'b00, 2'b00, 1, exp_cnt);
            if (exp_cnt < 15) exp_cnt++;
            cyc("sat_re", 0, 1, 1, 6, 11, 1, 0, 0, 2'b00, 2'b00, 0, exp_cnt);
        end
        cyc("sat_ex", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 15);
        idle("sat_idle", 3);

        // reset mid-flight discards records and clears the counter
        cyc("mr_p",   0, 1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0, 15);
        cyc("mr_rst", 1, 1, 3, 3, 4, 1, 0, 0, 2'b00, 2'b00, 0, 15);
        exp_cnt = 0;
        cyc("mr_after", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle("mr_idle", 2);

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It tracks destination-register state of the instructions in EX, MEM and WB and drives the two-bit selects of the ALU-operand forwarding 3-to-1 muxes (Mux_3_by_1, one per operand). It raises a load-use stall toward the fetch/decode stages and counts stall cycles for performance debug. It sits beside the ID/EX pipeline register and is clocked with it.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  ID stage holds a real instruction this cycle
- issue_rs1  in  REG_W  ID source register 1
- issue_rs2  in  REG_W  ID source register 2
- issue_rd  in  REG_W  ID destination register
- issue_regwrite  in  1  ID instruction writes rd
- issue_memread  in  1  ID instruction is a load
- flush  in  1  branch/jump taken in EX; kill the instruction entering EX
- forward_a  out  2  select for operand-A Mux_3_by_1
- forward_b  out  2  select for operand-B Mux_3_by_1
- stall  out  1  hold PC and IF/ID; bubble into EX
- stall_count  out  CNT_W  saturating count of stalled cycles

## Operation
- Internal stage records EX, MEM, WB, each: valid, rs1, rs2 (EX only), rd, regwrite, memread.
- Mux select encoding, fixed for both operands: 00 = register-file value (mux input a), 01 = WB result (input b), 10 = MEM ALU result (input c). 11 never driven.
- forward_a (combinational, from registered state):
  - 10 if EX.valid, MEM.valid, MEM.regwrite, MEM.rd != 0, MEM.rd == EX.rs1
  - else 01 if EX.valid, WB.valid, WB.regwrite, WB.rd != 0, WB.rd == EX.rs1
  - else 00. MEM has priority over WB (younger value wins).
- forward_b: identical, using EX.rs2.
- stall (combinational) = issue_valid & !flush & EX.valid & EX.memread & EX.regwrite & EX.rd != 0 & (EX.rd == issue_rs1 | EX.rd == issue_rs2). Both sources are always compared (conservative for instructions without rs2).
- Per clock, when rst = 0:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (valid = 0, other fields 0) if flush | stall | !issue_valid; otherwise EX <= issue_* fields with valid = 1.
  - stall_count += 1 when stall = 1 and stall_count != all-ones; holds at all-ones.
- x0 never forwards and never causes a stall.
- Upstream holds issue_* stable while stall = 1; the instruction is re-evaluated the next cycle and issues once the load has moved to MEM. It then gets forward select 01 from WB when it is in EX.

## Timing
- Reset: all stage valid bits 0, all fields 0. forward_a = forward_b = 00, stall = 0, stall_count = 0 in the cycle after rst is sampled high. rst mid-operation discards all in-flight records, with no forwarding from them afterwards.
- An instruction accepted at edge n is in EX during cycle n+1, MEM n+2, WB n+3. Forward selects for it are valid during cycle n+1.
- stall and forward_* have zero-cycle latency from current inputs and state. There is no register on the outputs.
- Load-use costs exactly one stall cycle per dependent instruction.
- flush and stall in the same cycle: flush wins, stall = 0, a bubble is inserted, and the counter does not increment.
- flush does not clear MEM or WB. Older instructions complete and keep forwarding.
- rst has priority over flush and issue.

## Test plan
- Reset: hold rst 2 cycles with issue_valid = 1 and rs1 = rd = 5 → forward_a/b = 00, stall = 0, stall_count = 0 during and after reset.
- EX→EX forwarding: issue add x3 (rd = 3, regwrite), then add x4, x3, x3 → in the second instruction's EX cycle, forward_a = forward_b = 10. An rd = 0 producer → 00.
- WB forwarding and priority: producers rd = 7 then rd = 7 then consumer rs1 = 7, rs2 = 8 → forward_a = 10 (MEM wins), forward_b = 00. With a non-writing middle instruction → forward_a = 01.
- Load-use: load rd = 6 (memread), then consumer rs2 = 6 → stall = 1 for exactly one cycle, a bubble is in EX, stall_count = 1. When the consumer reaches EX, forward_b = 01.
- Flush: same load-use pair with flush = 1 in the stall cycle → stall = 0, EX is a bubble the next cycle, stall_count unchanged. MEM-stage forwarding of older rd = 6 still occurs.
- Saturation: with CNT_W = 4, force 20 consecutive load-use stalls → stall_count stops at 15.
